// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

  // True when a nibble is a legal BCD digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nib);
    return nib <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-BCD shows a dash.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed BCD display scanner: shadow latch, slot prescaler,
// per-slot dead time, leading-zero blanking and a sticky non-BCD error flag.
module bcd_display_scan
  import disp_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_in,
  input  logic                            latch,
  input  logic                            blank_lz,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [SEG_W-1:0]                seg,
  output logic                            err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned BUS_W = NUM_DIGITS * DIGIT_W;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BUS_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  err_q, err_d;

  logic [DIGIT_W-1:0]    digit_sel_c;
  logic [SEG_W-1:0]      dec_seg_c;
  logic [NUM_DIGITS-1:0] zero_from_c;
  logic                  bad_c;
  logic                  blank_c;
  logic                  wrap_c;

  assign digit_sel_c = shadow_q[{idx_q, 2'b00} +: DIGIT_W];

  seg7_decode u_dec (
    .digit (digit_sel_c),
    .seg_c (dec_seg_c)
  );

  // zero_from_c[k]: digit k and every higher digit are zero.
  always_comb begin
    zero_from_c = '0;
    bad_c       = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (k == NUM_DIGITS - 1) begin
        zero_from_c[k] = (shadow_q[k*DIGIT_W +: DIGIT_W] == '0);
      end else begin
        zero_from_c[k] = zero_from_c[k+1] & (shadow_q[k*DIGIT_W +: DIGIT_W] == '0);
      end
      bad_c = bad_c | ~is_bcd(shadow_q[k*DIGIT_W +: DIGIT_W]);
    end
  end

  assign blank_c = blank_lz & (idx_q != '0) & zero_from_c[idx_q];
  assign wrap_c  = (cnt_q == CNT_W'(PRESCALE - 1));

  // Next-state: scan timing, shadow capture and registered display outputs.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = '1;
    seg_d    = SEG_OFF;
    err_d    = err_q | bad_c;

    if (wrap_c) begin
      cnt_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end

    if (latch) begin
      shadow_d = digits_in;
    end

    if (cnt_q != '0) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = blank_c ? SEG_OFF : dec_seg_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      err_q    <= err_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule
